// File: rtl/core_seq_fsm_if.sv
// rtl/core_seq_fsm_if.sv - instruction/data memory handshake bundle for core_seq_fsm
//
// Signals (directions as seen by the core through the master modport):
//   imem_req_o     out  instruction fetch request
//   imem_rvalid_i  in   instruction data valid
//   dmem_req_o     out  data access request
//   dmem_we_o      out  data write (store) qualifier
//   dmem_rvalid_i  in   data access complete
interface core_seq_fsm_if;
    logic imem_req_o;
    logic imem_rvalid_i;
    logic dmem_req_o;
    logic dmem_we_o;
    logic dmem_rvalid_i;

    modport master (
        output imem_req_o,
        output dmem_req_o,
        output dmem_we_o,
        input  imem_rvalid_i,
        input  dmem_rvalid_i
    );

    modport slave (
        input  imem_req_o,
        input  dmem_req_o,
        input  dmem_we_o,
        output imem_rvalid_i,
        output dmem_rvalid_i
    );
endinterface

// File: rtl/core_seq_fsm.sv
// rtl/core_seq_fsm.sv - multi-cycle instruction sequencer for the single-issue RV32 core
//
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and drives the
// PC/IR/register-file strobes plus a retired-instruction counter.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   halt_i               halt request, honoured at instruction boundary
//   mem                  memory handshake bundle (core_seq_fsm_if.master)
//   rwr_en_i .. uje_i    decoder class flags and ALU branch result
//   ir_we_o, pc_we_o     IR load and PC update pulses
//   pc_sel_o             0 PC+4, 1 branch, 2 JAL, 3 JALR
//   rf_we_o, wb_sel_o    register write pulse, 0 ALU / 1 load / 2 PC+4
//   instret_o            retired-instruction count (wraps)
//   state_o              current state for debug
//   bus_err_o            sticky memory timeout flag
//
// Optional: define MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES.
module core_seq_fsm #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             halt_i,
    core_seq_fsm_if.master   mem,
    input  logic             rwr_en_i,
    input  logic             dr_en_i,
    input  logic             dwr_en_i,
    input  logic             sb_en_i,
    input  logic             br_taken_i,
    input  logic             jalre_i,
    input  logic             uje_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             rf_we_o,
    output logic [1:0]       wb_sel_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [2:0]       state_o,
    output logic             bus_err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             timeout;
    logic             imem_req, dmem_req, dmem_we;

`ifdef MEM_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);

    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            bus_err_q, bus_err_d;

    // Fires on the last permitted wait cycle; a same-cycle rvalid takes
    // precedence in the FSM below, so the access still completes.
    assign timeout = (wait_cnt_q == WAIT_LAST);

    // Any state other than a stalled FETCH/MEM zeroes the counter, which
    // gives the clear-on-entry behaviour for both waiting states.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == S_FETCH && !mem.imem_rvalid_i) ||
            (state_q == S_MEM && !mem.dmem_rvalid_i)) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
        bus_err_d = bus_err_q | (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we_o   = 1'b0;
        pc_we_o   = 1'b0;
        rf_we_o   = 1'b0;
        pc_sel_o  = 2'd0;
        wb_sel_o  = 2'd0;
        case (state_q)
            S_IDLE: state_d = halt_i ? S_HALT : S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem.imem_rvalid_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (dr_en_i || dwr_en_i) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dwr_en_i;
                if (mem.dmem_rvalid_i) begin
                    state_d = S_WB;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we_o = rwr_en_i;
                pc_we_o = 1'b1;
                if (dr_en_i) begin
                    wb_sel_o = 2'd1;
                end else if (jalre_i || uje_i) begin
                    wb_sel_o = 2'd2;
                end
                if (uje_i) begin
                    pc_sel_o = 2'd2;
                end else if (jalre_i) begin
                    pc_sel_o = 2'd3;
                end else if (sb_en_i && br_taken_i) begin
                    pc_sel_o = 2'd1;
                end
                instret_d = instret_q + CNT_W'(1);
                state_d   = halt_i ? S_HALT : S_FETCH;
            end
            S_HALT: if (!halt_i) state_d = S_FETCH;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign mem.imem_req_o = imem_req;
    assign mem.dmem_req_o = dmem_req;
    assign mem.dmem_we_o  = dmem_we;
    assign instret_o      = instret_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_core_seq_fsm.sv
// tb/tb_core_seq_fsm.sv - self-checking bench for core_seq_fsm with a per-instruction reference model
module tb_core_seq_fsm;

    localparam int CNT_W = 4;
    localparam int TO    = 4;

    // Instruction kinds driven by the bench.
    localparam int K_ADDI = 0, K_LW = 1, K_SW = 2, K_BEQT = 3, K_BEQN = 4,
                   K_JAL = 5, K_JALR = 6, K_ADDBR = 7;

    logic             clk = 1'b0;
    logic             rst_ni, halt_i;
    logic             rwr_en, dr_en, dwr_en, sb_en, br_taken, jalre, uje;
    logic             ir_we, pc_we, rf_we, bus_err;
    logic [1:0]       pc_sel, wb_sel;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;
    logic [13:0]      obs;
    logic [13:0]      exp_v;

    int checks = 0;
    int passes = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    core_seq_fsm_if mif ();

    core_seq_fsm #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .halt_i     (halt_i),
        .mem        (mif),
        .rwr_en_i   (rwr_en),
        .dr_en_i    (dr_en),
        .dwr_en_i   (dwr_en),
        .sb_en_i    (sb_en),
        .br_taken_i (br_taken),
        .jalre_i    (jalre),
        .uje_i      (uje),
        .ir_we_o    (ir_we),
        .pc_we_o    (pc_we),
        .pc_sel_o   (pc_sel),
        .rf_we_o    (rf_we),
        .wb_sel_o   (wb_sel),
        .instret_o  (instret),
        .state_o    (state),
        .bus_err_o  (bus_err)
    );

    // {bus_err, state, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, pc_sel, wb_sel}
    assign obs = {bus_err, state, mif.imem_req_o, mif.dmem_req_o, mif.dmem_we_o,
                  ir_we, pc_we, rf_we, pc_sel, wb_sel};

    // Architectural meaning of each kind at writeback.
    function automatic logic [1:0] k_pc_sel(input int k);
        case (k)
            K_BEQT:  return 2'd1;
            K_JAL:   return 2'd2;
            K_JALR:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] k_wb_sel(input int k);
        case (k)
            K_LW:          return 2'd1;
            K_JAL, K_JALR: return 2'd2;
            default:       return 2'd0;
        endcase
    endfunction

    function automatic logic k_rf_we(input int k);
        return (k == K_ADDI || k == K_LW || k == K_JAL || k == K_JALR || k == K_ADDBR);
    endfunction

    task automatic set_flags(input int k);
        rwr_en   = k_rf_we(k);
        dr_en    = (k == K_LW);
        dwr_en   = (k == K_SW);
        sb_en    = (k == K_BEQT || k == K_BEQN);
        br_taken = (k == K_BEQT || k == K_ADDBR);
        jalre    = (k == K_JALR);
        uje      = (k == K_JAL);
    endtask

    // Runs one instruction starting just after the edge that entered FETCH.
    // iw/dw are extra wait cycles; hc>0 raises halt in EXEC and holds it hc cycles.
    task automatic do_instr(input int k, input int iw, input int dw, input int hc);
        bit is_mem;
        is_mem = (k == K_LW || k == K_SW);
        set_flags(k);
        for (int w = 0; w <= iw; w++) begin
            mif.imem_rvalid_i = (w == iw);
            mif.dmem_rvalid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = {1'b0, 3'd1, 1'b1, 2'b00, (w == iw), 2'b00, 2'd0, 2'd0};
            checks++;
            if (obs !== exp_v) $display("FAIL fetch k=%0d w=%0d got %b want %b", k, w, obs, exp_v);
            else passes++;
            @(posedge clk); #1;
        end
        for (int ph = 0; ph < 2; ph++) begin
            mif.imem_rvalid_i = 1'($urandom_range(0, 1));
            mif.dmem_rvalid_i = 1'($urandom_range(0, 1));
            if (ph == 1 && hc > 0) halt_i = 1'b1;
            @(negedge clk);
            exp_v = {1'b0, (ph == 0) ? 3'd2 : 3'd3, 10'd0};
            checks++;
            if (obs !== exp_v) $display("FAIL dec_exec k=%0d ph=%0d got %b want %b", k, ph, obs, exp_v);
            else passes++;
            @(posedge clk); #1;
        end
        if (is_mem) begin
            for (int w = 0; w <= dw; w++) begin
                mif.imem_rvalid_i = 1'($urandom_range(0, 1));
                mif.dmem_rvalid_i = (w == dw);
                @(negedge clk);
                exp_v = {1'b0, 3'd4, 1'b0, 1'b1, (k == K_SW), 3'b000, 2'd0, 2'd0};
                checks++;
                if (obs !== exp_v) $display("FAIL mem k=%0d w=%0d got %b want %b", k, w, obs, exp_v);
                else passes++;
                @(posedge clk); #1;
            end
        end
        mif.imem_rvalid_i = 1'($urandom_range(0, 1));
        mif.dmem_rvalid_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_v = {1'b0, 3'd5, 3'b000, 1'b0, 1'b1, k_rf_we(k), k_pc_sel(k), k_wb_sel(k)};
        checks++;
        if (obs !== exp_v) $display("FAIL wb k=%0d got %b want %b", k, obs, exp_v);
        else passes++;
        @(posedge clk); #1;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        checks++;
        if (instret !== CNT_W'(exp_cnt)) $display("FAIL instret k=%0d got %0d want %0d", k, instret, exp_cnt);
        else passes++;
        if (hc > 0) begin
            for (int h = 0; h <= hc; h++) begin
                if (h == hc) halt_i = 1'b0;
                mif.imem_rvalid_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                exp_v = {1'b0, 3'd6, 10'd0};
                checks++;
                if (obs !== exp_v) $display("FAIL halt h=%0d got %b want %b", h, obs, exp_v);
                else passes++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        halt_i = 1'b0;
        set_flags(K_ADDI);
        mif.imem_rvalid_i = 1'b0;
        mif.dmem_rvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (obs !== 14'd0) $display("FAIL reset_outputs got %b want %b", obs, 14'd0);
        else passes++;
        checks++;
        if (instret !== '0) $display("FAIL reset_instret got %0d want 0", instret);
        else passes++;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 14'd0) $display("FAIL idle got %b want %b", obs, 14'd0);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_instr(K_ADDI, 1, 0, 0);
        do_instr(K_LW,   0, 3, 0);
        do_instr(K_SW,   0, 1, 0);
        do_instr(K_BEQT, 0, 0, 0);
        do_instr(K_BEQN, 0, 0, 0);
        do_instr(K_JAL,  0, 0, 0);
        do_instr(K_JALR, 0, 0, 0);
        do_instr(K_ADDBR, 0, 0, 0);
        do_instr(K_ADDI, 0, 0, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) do_instr(K_ADDI, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic test_reset_mid();
        set_flags(K_LW);
        mif.imem_rvalid_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mif.imem_rvalid_i = 1'b0;
        mif.dmem_rvalid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || mif.dmem_req_o !== 1'b1)
            $display("FAIL pre_reset_mem got state=%0d req=%b want 4/1", state, mif.dmem_req_o);
        else passes++;
        @(posedge clk); #1;
        exp_cnt = 0;
        checks++;
        if (obs !== 14'd0 || instret !== '0)
            $display("FAIL reset_mid got %b cnt=%0d want %b cnt=0", obs, instret, 14'd0);
        else passes++;
        rst_ni = 1'b1;
        halt_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state !== 3'd6 || mif.imem_req_o !== 1'b0)
            $display("FAIL idle_halt got state=%0d req=%b want 6/0", state, mif.imem_req_o);
        else passes++;
        halt_i = 1'b0;
        @(posedge clk); #1;
        do_instr(K_SW, 2, 0, 0);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        rst_ni = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 3'd1, 1'b1, 9'd0};
            checks++;
            if (obs !== exp_v) $display("FAIL to_fetch i=%0d got %b want %b", i, obs, exp_v);
            else passes++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            mif.imem_rvalid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = {1'b1, 3'd7, 10'd0};
            checks++;
            if (obs !== exp_v) $display("FAIL to_err i=%0d got %b want %b", i, obs, exp_v);
            else passes++;
            @(posedge clk); #1;
        end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 14'd0) $display("FAIL to_reset got %b want %b", obs, 14'd0);
        else passes++;
        rst_ni = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
